// File: rtl/tdm_demux_pkg.sv
// ----------------------------------------------------------------------------
// tdm_demux_pkg
// Shared types and constants for the 1-to-4 TDM demultiplexer.
//   NCH       : number of output channels (slots per frame)
//   slot_t    : 2-bit slot index, wraps 3 -> 0
//   state_t   : framing FSM states (IDLE = waiting for first frame_sync,
//               RUN = locked to the frame)
//   SLOT_LAST : index of the final slot in a frame
// ----------------------------------------------------------------------------
package tdm_demux_pkg;

    localparam int NCH = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam slot_t SLOT_LAST = 2'd3;

endpackage

// File: rtl/tdm_demux_1to4_if.sv
// ----------------------------------------------------------------------------
// tdm_demux_1to4_if
// Bundles the serial TDM input and the four demultiplexed channel outputs.
//   din, din_valid, frame_sync : serial beat stream (driven by the link side)
//   ch0..ch3                   : registered channel data
//   ch_valid                   : per-channel one-cycle update strobes
//   slot                       : slot the next valid beat will be written to
//   frame_done, sync_err       : one-cycle frame status pulses
// Modports:
//   master : link/stimulus side, drives the stream and observes the channels
//   slave  : demultiplexer side, consumes the stream and drives the channels
// ----------------------------------------------------------------------------
interface tdm_demux_1to4_if #(
    parameter int WIDTH = 1
);
    import tdm_demux_pkg::*;

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] ch0;
    logic [WIDTH-1:0] ch1;
    logic [WIDTH-1:0] ch2;
    logic [WIDTH-1:0] ch3;
    logic [NCH-1:0]   ch_valid;
    slot_t            slot;
    logic             frame_done;
    logic             sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  ch0, ch1, ch2, ch3, ch_valid, slot, frame_done, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output ch0, ch1, ch2, ch3, ch_valid, slot, frame_done, sync_err
    );

endinterface

// File: rtl/tdm_slot_ctr.sv
// ----------------------------------------------------------------------------
// tdm_slot_ctr
// 2-bit slot counter for the TDM demultiplexer.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (counter -> 0)
//   i_en     : advance to the next slot (wraps 3 -> 0)
//   i_load1  : synchronous load of slot 1 (frame start beat just consumed);
//              takes priority over i_en
//   o_slot   : current slot index
//   o_wrap   : high while the counter sits on the last slot
// ----------------------------------------------------------------------------
module tdm_slot_ctr
    import tdm_demux_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_en,
    input  logic  i_load1,
    output slot_t o_slot,
    output logic  o_wrap
);

    slot_t r_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else if (i_load1) begin
            r_slot <= slot_t'(1);
        end else if (i_en) begin
            r_slot <= r_slot + slot_t'(1);
        end
    end

    assign o_slot = r_slot;
    assign o_wrap = (r_slot == SLOT_LAST);

endmodule

// File: rtl/tdm_demux_1to4.sv
// ----------------------------------------------------------------------------
// tdm_demux_1to4
// Receive-side time-division demultiplexer: beat k of each frame (k = 0..3)
// is routed to registered output channel k. frame_sync marks slot 0; once
// locked, frames may follow back-to-back without further syncs. A sync that
// arrives mid-frame aborts the partial frame and raises sync_err.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tdm_demux_1to4_if.slave (stream in, channels/status out)
//
// Build option:
//   TDM_DEMUX_FRAME_LATCH_EN - beats collect in shadow registers and all four
//   channels update together when slot 3 is captured (ch_valid = 1111 with
//   frame_done). Aborted frames never reach the outputs. When undefined each
//   channel updates as its own beat is captured.
// ----------------------------------------------------------------------------
module tdm_demux_1to4
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    tdm_demux_1to4_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    slot_t            w_slot;
    slot_t            w_wr_slot;
    logic             w_wrap;
    logic             w_wr;
    logic             w_ctr_en;
    logic             w_ctr_load;
    logic             w_sync_err;
    logic             w_frame_done;

    logic [WIDTH-1:0] r_ch [NCH];
    logic [NCH-1:0]   r_ch_valid;
    logic             r_frame_done;
    logic             r_sync_err;

    tdm_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_ctr_en),
        .i_load1 (w_ctr_load),
        .o_slot  (w_slot),
        .o_wrap  (w_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr         = 1'b0;
        w_ctr_en     = 1'b0;
        w_ctr_load   = 1'b0;
        w_sync_err   = 1'b0;
        w_frame_done = 1'b0;
        if (bus.din_valid) begin
            case (r_state)
                IDLE: begin
                    // Until the first sync the stream position is unknown.
                    if (bus.frame_sync) begin
                        w_wr        = 1'b1;
                        w_ctr_load  = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    w_wr = 1'b1;
                    if (bus.frame_sync) begin
                        // Sync on slot 0 is just a redundant marker.
                        w_ctr_load = 1'b1;
                        w_sync_err = (w_slot != '0);
                    end else begin
                        w_ctr_en     = 1'b1;
                        w_frame_done = w_wrap;
                    end
                end
            endcase
        end
    end

    // A sync beat always lands in channel 0, wherever the counter stood.
    assign w_wr_slot = bus.frame_sync ? slot_t'(0) : w_slot;

`ifdef TDM_DEMUX_FRAME_LATCH_EN
    // Slots 0..2 wait here; slot 3 goes straight to the outputs with them.
    logic [WIDTH-1:0] r_shd [SLOT_LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SLOT_LAST; k++) begin
                r_shd[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SLOT_LAST; k++) begin
                if (w_wr && (w_wr_slot == slot_t'(k))) begin
                    r_shd[k] <= bus.din;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                r_ch[k] <= '0;
            end
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_ch_valid   <= '0;
            r_frame_done <= w_frame_done;
            r_sync_err   <= w_sync_err;
            if (w_frame_done) begin
                for (int k = 0; k < SLOT_LAST; k++) begin
                    r_ch[k] <= r_shd[k];
                end
                r_ch[SLOT_LAST] <= bus.din;
                r_ch_valid      <= '1;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                r_ch[k] <= '0;
            end
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_ch_valid   <= '0;
            r_frame_done <= w_frame_done;
            r_sync_err   <= w_sync_err;
            if (w_wr) begin
                r_ch[w_wr_slot]       <= bus.din;
                r_ch_valid[w_wr_slot] <= 1'b1;
            end
        end
    end
`endif

    assign bus.ch0        = r_ch[0];
    assign bus.ch1        = r_ch[1];
    assign bus.ch2        = r_ch[2];
    assign bus.ch3        = r_ch[3];
    assign bus.ch_valid   = r_ch_valid;
    assign bus.slot       = w_slot;
    assign bus.frame_done = r_frame_done;
    assign bus.sync_err   = r_sync_err;

endmodule

// File: doc/tdm_demux_1to4.md
Name: tdm_demux_1to4

Overview:
Time-division demultiplexer, the receive-side counterpart to the 4-to-1 channel multiplexer.
- Accepts one serial TDM stream of WIDTH-bit beats, framed by a frame_sync marker.
- Routes beat k of each frame into registered output channel k (k = 0..3).
- Flags frame completion and framing errors.
- Sits between the mux/serial link and the per-channel consumers.

Parameters:
- WIDTH, 1, bit width of each beat and of each output channel.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  serial beat data.
- din_valid  input  1  beat qualifier; a beat is consumed only when this is high.
- frame_sync  input  1  marks the current valid beat as slot 0 of a new frame; ignored when din_valid=0.
- ch0, ch1, ch2, ch3  output  WIDTH each  registered channel outputs.
- ch_valid  output  4  one-cycle strobe per channel, bit k set in the cycle after chk updates.
- slot  output  2  slot index the next valid beat will be written to.
- frame_done  output  1  one-cycle pulse after slot 3 is captured.
- sync_err  output  1  one-cycle pulse when frame_sync arrives mid-frame.

Behaviour:
- Reset (rst_n low, asynchronous):
  - ch0..ch3 = 0, ch_valid = 0, slot = 0, frame_done = 0, sync_err = 0.
  - state = IDLE.
  - Reset asserted mid-frame discards the partial frame immediately.
- States: IDLE, RUN.
- IDLE:
  - Valid beats without frame_sync are dropped; no outputs change.
  - Valid beat with frame_sync: write ch0, ch_valid = 0001 next cycle, slot -> 1, go to RUN.
- RUN, valid beat without frame_sync:
  - Write ch[slot], set ch_valid bit slot next cycle, slot increments.
  - At slot 3: pulse frame_done, slot wraps to 0, stay in RUN. Back-to-back frames need no frame_sync.
- RUN, valid beat with frame_sync:
  - If slot == 0: normal frame start, no error.
  - If slot != 0: pulse sync_err; the beat is written to ch0; slot -> 1; no frame_done for the truncated frame; unwritten channels keep their old values.
- din_valid low: no writes, slot holds, ch_valid = 0. Gaps of any length inside a frame are legal.
- Latency: one clock from valid beat to chk and its ch_valid bit; frame_done is coincident with ch_valid[3].
- ch_valid is a strobe, never held high; channels hold their value between writes.
- slot is 2-bit unsigned and wraps 3 -> 0.

Optional Feature:
- Macro: TDM_DEMUX_FRAME_LATCH_EN.
- Defined:
  - Beats go into internal shadow registers.
  - ch0..ch3 update together, one cycle after slot 3 is captured; ch_valid = 1111 in that cycle, coincident with frame_done.
  - A frame aborted by sync_err never reaches the outputs.
- Undefined: per-slot update exactly as described above; no shadow registers.

Decomposition:
- Package tdm_demux_pkg holds:
  - NCH = 4.
  - slot_t (2-bit).
  - state_t enum {IDLE, RUN}.
  - SLOT_LAST = 3.
- Sub-module tdm_slot_ctr: 2-bit slot counter with enable, sync-load-to-1, wrap detect and async reset.
- Top level holds the FSM, channel and shadow registers, and the strobes.

Test Plan:
- Reset mid-frame: after 2 beats, pulse rst_n low -> all outputs 0 asynchronously, state IDLE; a following beat without sync is ignored.
- Clean frame, WIDTH=1: sync + beats 1,0,1,1 consecutive -> ch0..3 = 1,0,1,1; ch_valid = 0001, 0010, 0100, 1000 on successive cycles; frame_done with the last.
- Gaps: the same frame with din_valid low for 3 cycles between beats 1 and 2 -> identical captures, slot holds during the gap, no spurious strobes.
- Resync error: sync, beats A, B, then sync + beat C -> sync_err pulse, ch0 = C, slot = 1, no frame_done; a following 3 beats complete the frame normally.
- Back-to-back: two frames without a second sync -> two frame_done pulses 4 valid beats apart, slot wraps 3 -> 0.
- FRAME_LATCH_EN: with the macro defined, rerun the clean-frame and resync tests -> outputs unchanged until the last beat, then all four update together with ch_valid = 1111; the aborted frame leaves outputs untouched.
